// File: rtl/riscv_io_pkg.sv
`default_nettype none
// ============================================================================
// Package : riscv_io_pkg
// Register map offsets and bus operation type for the RISC-V I/O controller.
// Rev     : 1.0
// ============================================================================
package riscv_io_pkg;

    localparam logic [7:0] IN_BASE    = 8'h00;
    localparam logic [7:0] OUT_BASE   = 8'h40;
    localparam logic [7:0] STATUS_OFF = 8'h80;
    localparam logic [7:0] IRQEN_OFF  = 8'h84;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } bus_op_t;

    // Channel index inside the IN or OUT window (word offset within 64 bytes).
    function automatic logic [3:0] chan_idx(input logic [7:0] addr);
        return addr[5:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_io_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module : io_debounce
// Two-flop synchroniser plus stable-sample counter for one input channel.
// Rev    : 1.0
// ============================================================================
module io_debounce #(
    parameter int DATA_W  = 32,
    parameter int DEB_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_i,
    output logic [DATA_W-1:0] deb_o,
    output logic              chg_o
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic [DATA_W-1:0] sync1_q, sync2_q, cand_q, deb_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // The count includes the sample being taken, so a fresh value starts at one.
    always_comb begin
        if (sync2_q != cand_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(DEB_CYC)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign chg_o = (cnt_d == CNT_W'(DEB_CYC)) && (sync2_q != deb_q);
    assign deb_o = deb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= cnt_d;
            if (chg_o) begin
                deb_q <= sync2_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module : riscv_io_ctrl
// Memory-mapped debounced inputs, output registers and maskable change IRQ.
// Rev    : 1.0
// ============================================================================
module riscv_io_ctrl
    import riscv_io_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_IN    = 2,
    parameter int N_OUT   = 2,
    parameter int DEB_CYC = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN*DATA_W-1:0]  sw_in,
    input  logic                    bus_req,
    input  logic                    bus_we,
    input  logic [7:0]              bus_addr,
    input  logic [31:0]             bus_wdata,
    output logic [31:0]             bus_rdata,
    output logic                    bus_ack,
    output logic                    bus_err,
    output logic [N_OUT*DATA_W-1:0] out_port,
    output logic                    irq
);

    logic [DATA_W-1:0]       deb_val [N_IN];
    logic [N_IN-1:0]         chg;
    logic [N_IN-1:0]         w1c;
    logic [N_IN-1:0]         status_q, status_d, irqen_q, irqen_d;
    logic [N_OUT*DATA_W-1:0] out_q, out_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ack_q, err_q, err_d, irq_q;
    bus_op_t                 op;
    logic [3:0]              idx;

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        io_debounce #(
            .DATA_W  (DATA_W),
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .sw_i  (sw_in[g*DATA_W +: DATA_W]),
            .deb_o (deb_val[g]),
            .chg_o (chg[g])
        );
    end

    assign op  = '{we: bus_we, addr: bus_addr, wdata: bus_wdata};
    assign idx = chan_idx(op.addr);

    // Error paths leave rdata_d at zero and touch no register.
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        out_d   = out_q;
        irqen_d = irqen_q;
        w1c     = '0;
        if (bus_req) begin
            if (op.addr[1:0] != 2'b00) begin
                err_d = 1'b1;
            end else if (op.addr[7:6] == IN_BASE[7:6]) begin
                if (op.we || (32'(idx) >= N_IN)) begin
                    err_d = 1'b1;
                end else begin
                    for (int i = 0; i < N_IN; i++) begin
                        if (idx == i[3:0]) rdata_d = 32'(deb_val[i]);
                    end
                end
            end else if (op.addr[7:6] == OUT_BASE[7:6]) begin
                if (32'(idx) >= N_OUT) begin
                    err_d = 1'b1;
                end else begin
                    for (int j = 0; j < N_OUT; j++) begin
                        if (idx == j[3:0]) begin
                            if (op.we) out_d[j*DATA_W +: DATA_W] = op.wdata[DATA_W-1:0];
                            else       rdata_d = 32'(out_q[j*DATA_W +: DATA_W]);
                        end
                    end
                end
            end else if (op.addr == STATUS_OFF) begin
                if (op.we) w1c = op.wdata[N_IN-1:0];
                else       rdata_d = 32'(status_q);
            end else if (op.addr == IRQEN_OFF) begin
                if (op.we) irqen_d = op.wdata[N_IN-1:0];
                else       rdata_d = 32'(irqen_q);
            end else begin
                err_d = 1'b1;
            end
        end
        // A new change event beats a simultaneous clear of the same bit.
        status_d = (status_q & ~w1c) | chg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            out_q    <= '0;
            status_q <= '0;
            irqen_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= bus_req;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            out_q    <= out_d;
            status_q <= status_d;
            irqen_q  <= irqen_d;
            irq_q    <= |(status_q & irqen_q);
        end
    end

    assign bus_ack   = ack_q;
    assign bus_err   = err_q;
    assign bus_rdata = rdata_q;
    assign out_port  = out_q;
    assign irq       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_riscv_io_ctrl
// Directed stimulus with a register-map level reference model for riscv_io_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_riscv_io_ctrl;

    localparam int DATA_W  = 32;
    localparam int N_IN    = 2;
    localparam int N_OUT   = 2;
    localparam int DEB_CYC = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_IN*DATA_W-1:0]  sw_in;
    logic                    bus_req, bus_we;
    logic [7:0]              bus_addr;
    logic [31:0]             bus_wdata, bus_rdata;
    logic                    bus_ack, bus_err, irq;
    logic [N_OUT*DATA_W-1:0] out_port;

    always #5 clk = ~clk;

    riscv_io_ctrl #(
        .DATA_W (DATA_W), .N_IN (N_IN), .N_OUT (N_OUT), .DEB_CYC (DEB_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_in     (sw_in),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .out_port  (out_port),
        .irq       (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of raw input samples, register file, expected outputs.
    logic [DATA_W-1:0] hist   [N_IN][DEB_CYC+1];
    logic [DATA_W-1:0] m_deb  [N_IN];
    logic [DATA_W-1:0] m_out  [N_OUT];
    logic [N_IN-1:0]   m_status, m_irqen;
    logic              e_ack, e_err, e_irq;
    logic [31:0]       e_rdata;
    bit                started = 0;

    always @(posedge clk) begin : model
        logic [N_IN-1:0] fired;
        logic [N_IN-1:0] clr;
        int              ch;
        bit              stable;
        if (reset) begin
            for (int c = 0; c < N_IN; c++) begin
                m_deb[c] = '0;
                for (int k = 0; k <= DEB_CYC; k++) hist[c][k] = '0;
            end
            for (int c = 0; c < N_OUT; c++) m_out[c] = '0;
            m_status = '0; m_irqen = '0;
            e_ack = 0; e_err = 0; e_irq = 0; e_rdata = '0;
        end else begin
            e_irq   = |(m_status & m_irqen);
            e_ack   = bus_req;
            e_err   = 0;
            e_rdata = '0;
            clr     = '0;
            fired   = '0;
            if (bus_req) begin
                if (bus_addr % 4 != 0) begin
                    e_err = 1;
                end else if (bus_addr < 8'h40) begin
                    ch = bus_addr / 4;
                    if (bus_we || ch >= N_IN) e_err = 1;
                    else e_rdata = 32'(m_deb[ch]);
                end else if (bus_addr < 8'h80) begin
                    ch = (bus_addr - 8'h40) / 4;
                    if (ch >= N_OUT) e_err = 1;
                    else if (bus_we) m_out[ch] = bus_wdata[DATA_W-1:0];
                    else e_rdata = 32'(m_out[ch]);
                end else if (bus_addr == 8'h80) begin
                    if (bus_we) clr = bus_wdata[N_IN-1:0];
                    else e_rdata = 32'(m_status);
                end else if (bus_addr == 8'h84) begin
                    if (bus_we) m_irqen = bus_wdata[N_IN-1:0];
                    else e_rdata = 32'(m_irqen);
                end else begin
                    e_err = 1;
                end
            end
            // Accept a value once it was seen DEB_CYC times in a row, two cycles late.
            for (int c = 0; c < N_IN; c++) begin
                stable = 1;
                for (int k = 2; k <= DEB_CYC; k++)
                    if (hist[c][k] != hist[c][1]) stable = 0;
                if (stable && hist[c][1] != m_deb[c]) begin
                    fired[c] = 1'b1;
                    m_deb[c] = hist[c][1];
                end
                for (int k = DEB_CYC; k >= 1; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = sw_in[c*DATA_W +: DATA_W];
            end
            m_status = (m_status & ~clr) | fired;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_ack", bus_ack, e_ack);
            chk("cyc_err", bus_err, e_err);
            chk("cyc_rdata", bus_rdata, e_rdata);
            chk("cyc_irq", irq, e_irq);
            for (int c = 0; c < N_OUT; c++)
                chk("cyc_out_port", out_port[c*DATA_W +: DATA_W], m_out[c]);
        end
    end

    logic [31:0]             l_rd;
    logic                    l_err, l_ack, l_irq;
    logic [N_OUT*DATA_W-1:0] l_out;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic bus(input logic we, input logic [7:0] addr, input logic [31:0] wd, input bit last);
        bus_req = 1; bus_we = we; bus_addr = addr; bus_wdata = wd;
        @(posedge clk);
        #1;
        l_ack = bus_ack; l_err = bus_err; l_rd = bus_rdata; l_irq = irq; l_out = out_port;
        chk("bus_ack", l_ack, 1'b1);
        #1;
        if (last) begin
            bus_req = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1; sw_in = '1;
        bus_req = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0;
        tick(2);
        reset = 0;
        chk("rst_ack", bus_ack, 1'b0);
        chk("rst_err", bus_err, 1'b0);
        chk("rst_rdata", bus_rdata, 32'h0);
        chk("rst_out_port", out_port, 64'h0);
        chk("rst_irq", irq, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_out_port", out_port, 64'h0);
        chk("post_rst_irq", irq, 1'b0);
        #1;
        sw_in = '0;
        tick(10);

        // Debounce latency: 2 sync + 4 stable samples
        sw_in[0 +: DATA_W] = 32'd7;
        tick(5);
        bus(0, 8'h00, 0, 1);
        chk("in0_before_update", l_rd, 32'd0);
        bus(0, 8'h00, 0, 1);
        chk("in0_after_update", l_rd, 32'd7);
        bus(0, 8'h80, 0, 1);
        chk("status_after_change", l_rd, 32'd1);
        bus(1, 8'h80, 32'h1, 1);

        sw_in[0 +: DATA_W] = 32'd5;
        tick(2);
        sw_in[0 +: DATA_W] = 32'd7;
        tick(10);
        bus(0, 8'h00, 0, 1);
        chk("in0_after_glitch", l_rd, 32'd7);
        bus(0, 8'h80, 0, 1);
        chk("status_after_glitch", l_rd, 32'd0);

        bus(1, 8'h44, 32'hDEAD_BEEF, 1);
        chk("out1_on_ack", l_out[63:32], 32'hDEAD_BEEF);
        bus(0, 8'h44, 0, 1);
        chk("out1_readback", l_rd, 32'hDEAD_BEEF);
        chk("out0_untouched", l_out[31:0], 32'h0);

        // Interrupt: status at cycle 6, irq one cycle later
        bus(1, 8'h84, 32'h1, 1);
        sw_in[0 +: DATA_W] = 32'd9;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (irq) begin
                n = k;
                break;
            end
        end
        chk("irq_rise_latency", n, 7);
        #1;
        bus(1, 8'h80, 32'h1, 1);
        chk("irq_on_clear_ack", l_irq, 1'b1);
        @(posedge clk);
        #1;
        chk("irq_after_clear", irq, 1'b0);
        #1;

        sw_in[0 +: DATA_W] = 32'd3;
        tick(5);
        bus(1, 8'h80, 32'h1, 1);
        bus(0, 8'h80, 0, 1);
        chk("status_set_wins", l_rd, 32'd1);
        bus(1, 8'h80, 32'h1, 1);
        bus(1, 8'h84, 32'h0, 1);

        bus(0, 8'h08, 0, 1);
        chk("err_in2_err", l_err, 1'b1);
        chk("err_in2_rdata", l_rd, 32'h0);
        bus(1, 8'h00, 32'hFFFF, 1);
        chk("err_write_in", l_err, 1'b1);
        bus(0, 8'h00, 0, 1);
        chk("in0_unchanged_err", l_err, 1'b0);
        chk("in0_unchanged", l_rd, 32'd3);
        bus(0, 8'h41, 0, 1);
        chk("err_misaligned", l_err, 1'b1);
        bus(0, 8'h48, 0, 1);
        chk("err_out2", l_err, 1'b1);
        bus(0, 8'h88, 0, 1);
        chk("err_unmapped", l_err, 1'b1);

        bus(1, 8'h40, 32'h11, 0);
        bus(0, 8'h40, 0, 0);
        chk("b2b_out0", l_rd, 32'h11);
        bus(0, 8'h04, 0, 1);
        chk("b2b_in1", l_rd, 32'h0);

        bus(1, 8'h44, 32'hCAFE, 0);
        chk("pre_rst_out1", l_out[63:32], 32'hCAFE);
        bus_we = 0; bus_addr = 8'h40; reset = 1;
        @(posedge clk);
        #1;
        chk("midrst_ack", bus_ack, 1'b0);
        chk("midrst_out_port", out_port, 64'h0);
        #1;
        reset = 0; bus_req = 0;
        @(posedge clk);
        #1;
        chk("midrst_no_late_ack", bus_ack, 1'b0);
        #1;
        bus(0, 8'h00, 0, 0);
        chk("midrst_in0", l_rd, 32'h0);
        bus(0, 8'h80, 0, 0);
        chk("midrst_status", l_rd, 32'h0);
        bus(0, 8'h84, 0, 0);
        chk("midrst_irqen", l_rd, 32'h0);
        bus(0, 8'h40, 0, 0);
        chk("midrst_out0", l_rd, 32'h0);
        bus(0, 8'h44, 0, 1);
        chk("midrst_out1", l_rd, 32'h0);
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
